time_counter: RTL

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter_if.sv | 31 +++
 rtl/time_counter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/time_counter_if.sv
// Control, preset and count-display bundle for the time_counter block.
// The master side drives controls and presets; the slave side drives counts and status.
interface time_counter_if;
    logic       en;
    logic       dir;
    logic       clr;
    logic       load;
    logic [7:0] LprogH;
    logic [7:0] LprogM;
    logic [7:0] LprogS;
    logic [7:0] CcountH;
    logic [7:0] CcountM;
    logic [7:0] CcountS;
    logic       tick;
    logic       wrap;
    logic       zero;
    logic       load_err;

    // No valid/ready handshake here: load and clr are single-cycle strobes
    // sampled on the rising clock edge, and tick/wrap/load_err are one-cycle
    // pulses that need no acknowledge.
    modport master (
        output en, dir, clr, load, LprogH, LprogM, LprogS,
        input  CcountH, CcountM, CcountS, tick, wrap, zero, load_err
    );

    modport slave (
        input  en, dir, clr, load, LprogH, LprogM, LprogS,
        output CcountH, CcountM, CcountS, tick, wrap, zero, load_err
    );
endinterface

// File: rtl/time_counter.sv
// 24-hour BCD up/down time counter with a clock prescaler, preset load
// with range checking, and one-cycle tick/wrap/load_err pulses.
module time_counter #(
    parameter int CLK_DIV = 100000000
) (
    input  logic          clock,
    input  logic          reset,
    time_counter_if.slave bus
);

    localparam int             PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  ONE  = PW'(1);

    logic [PW-1:0] presc;
    logic [7:0]    cnt_h;
    logic [7:0]    cnt_m;
    logic [7:0]    cnt_s;
    logic          tick_q;
    logic          wrap_q;
    logic          load_err_q;

    logic          at_last;
    logic          at_max;
    logic          at_zero;
    logic          load_ok;
    logic [8:0]    s_inc;
    logic [8:0]    m_inc;
    logic [8:0]    h_inc;
    logic [8:0]    s_dec;
    logic [8:0]    m_dec;
    logic [8:0]    h_dec;
    logic [7:0]    nxt_h;
    logic [7:0]    nxt_m;
    logic [7:0]    nxt_s;

    // Returns {carry, next}; rolls to 00 with carry when v equals max.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [8:0] r;
        if (v == max)
            r = {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Returns {borrow, next}; rolls from 00 to max with borrow.
    function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [8:0] r;
        if (v == 8'h00)
            r = {1'b1, max};
        else if (v[3:0] == 4'd0)
            r = {1'b0, v[7:4] - 4'd1, 4'd9};
        else
            r = {1'b0, v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    always_comb begin
        at_last = (presc == LAST);
        at_max  = ({cnt_h, cnt_m, cnt_s} == 24'h235959);
        at_zero = ({cnt_h, cnt_m, cnt_s} == 24'h000000);
        load_ok = bcd_in_range(bus.LprogH, 8'h23) &&
                  bcd_in_range(bus.LprogM, 8'h59) &&
                  bcd_in_range(bus.LprogS, 8'h59);

        s_inc = bcd_inc(cnt_s, 8'h59);
        m_inc = bcd_inc(cnt_m, 8'h59);
        h_inc = bcd_inc(cnt_h, 8'h23);
        s_dec = bcd_dec(cnt_s, 8'h59);
        m_dec = bcd_dec(cnt_m, 8'h59);
        h_dec = bcd_dec(cnt_h, 8'h23);

        nxt_h = cnt_h;
        nxt_m = cnt_m;
        nxt_s = cnt_s;
        if (!bus.dir) begin
            nxt_s = s_inc[7:0];
            if (s_inc[8]) nxt_m = m_inc[7:0];
            if (s_inc[8] && m_inc[8]) nxt_h = h_inc[7:0];
        end else if (!at_zero) begin
            // Down count stops at 00:00:00, so the hours borrow never rolls.
            nxt_s = s_dec[7:0];
            if (s_dec[8]) nxt_m = m_dec[7:0];
            if (s_dec[8] && m_dec[8]) nxt_h = h_dec[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            cnt_h      <= 8'h00;
            cnt_m      <= 8'h00;
            cnt_s      <= 8'h00;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.clr) begin
                presc <= '0;
                cnt_h <= 8'h00;
                cnt_m <= 8'h00;
                cnt_s <= 8'h00;
            end else if (bus.load) begin
                if (load_ok) begin
                    presc <= '0;
                    cnt_h <= bus.LprogH;
                    cnt_m <= bus.LprogM;
                    cnt_s <= bus.LprogS;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.en) begin
                if (at_last) begin
                    presc  <= '0;
                    tick_q <= 1'b1;
                    wrap_q <= !bus.dir && at_max;
                    cnt_h  <= nxt_h;
                    cnt_m  <= nxt_m;
                    cnt_s  <= nxt_s;
                end else begin
                    presc <= presc + ONE;
                end
            end
        end
    end

    assign bus.CcountH  = cnt_h;
    assign bus.CcountM  = cnt_m;
    assign bus.CcountS  = cnt_s;
    assign bus.tick     = tick_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.zero     = at_zero;

endmodule
